// File: rtl/throu8_seq.sv
// Micro-sequencer for the 8-bit pass-through unit: reads a source register,
// applies clear/move/swap cnt+1 times with feedback, writes the destination.
module throu8_seq #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [REG_AW-1:0] i_cmd_src,
    input  logic [REG_AW-1:0] i_cmd_dst,
    input  logic [CNT_W-1:0]  i_cmd_cnt,
    output logic [REG_AW-1:0] o_rf_raddr,
    input  logic [7:0]        i_rf_rdata,
    output logic              o_rf_we,
    output logic [REG_AW-1:0] o_rf_waddr,
    output logic [7:0]        o_rf_wdata,
    output logic [7:0]        o_dp_oprd,
    output logic              o_dp_clr,
    output logic              o_dp_swap_n_mov,
    input  logic [7:0]        i_dp_tout,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_SWAP = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EXEC,
        S_WB,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_op;
    logic [REG_AW-1:0]   r_dst;
    logic [REG_AW-1:0]   r_raddr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_first;
    logic [7:0]          r_result;
    logic                w_accept;

    assign o_cmd_ready = (r_state == S_IDLE) & ~i_rst;
    assign w_accept    = i_cmd_valid & o_cmd_ready;
    assign o_busy      = (r_state != S_IDLE);
    assign o_rf_raddr  = r_raddr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_MOV;
            r_dst    <= '0;
            r_raddr  <= '0;
            r_cnt    <= '0;
            r_first  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= i_cmd_op;
                r_dst   <= i_cmd_dst;
                r_raddr <= i_cmd_src;
                r_cnt   <= i_cmd_cnt;
                r_first <= 1'b1;
            end
            // Each EXEC cycle folds the unit's output back in as the next operand
            if (r_state == S_EXEC) begin
                r_result <= i_dp_tout;
                r_first  <= 1'b0;
                if (r_cnt != '0)
                    r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        o_rf_we         = 1'b0;
        o_rf_waddr      = '0;
        o_rf_wdata      = '0;
        o_dp_oprd       = '0;
        o_dp_clr        = 1'b0;
        o_dp_swap_n_mov = 1'b0;
        o_done          = 1'b0;
        o_err           = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    unique case (i_cmd_op)
                        OP_MOV, OP_SWAP: w_next = S_RD;
                        OP_CLR:          w_next = S_EXEC;
                        default:         w_next = S_ERR;
                    endcase
                end
            end
            S_RD: w_next = S_EXEC;
            S_EXEC: begin
                o_dp_clr        = (r_op == OP_CLR);
                o_dp_swap_n_mov = (r_op == OP_SWAP);
                if (r_op != OP_CLR)
                    o_dp_oprd = r_first ? i_rf_rdata : r_result;
                if (r_cnt == '0)
                    w_next = S_WB;
            end
            S_WB: begin
                o_rf_we    = 1'b1;
                o_rf_waddr = r_dst;
                o_rf_wdata = r_result;
                o_done     = 1'b1;
                w_next     = S_IDLE;
            end
            S_ERR: begin
                o_err  = 1'b1;
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_throu8_seq.sv
// Directed bench for throu8_seq with a behavioural register file
// and pass-through unit.
module tb_throu8_seq;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_src;
    logic [2:0] cmd_dst;
    logic [3:0] cmd_cnt;
    logic [2:0] rf_raddr;
    logic [7:0] rf_rdata;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [7:0] dp_oprd;
    logic       dp_clr;
    logic       dp_swap;
    logic [7:0] dp_tout;
    logic       busy;
    logic       done;
    logic       err;

    logic [7:0]  mem [8];
    logic [10:0] wr_q [$];
    int          done_cnt;
    int          err_cnt;
    int          nvec;
    int          nerr;

    throu8_seq #(.REG_AW(3), .CNT_W(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_op       (cmd_op),
        .i_cmd_src      (cmd_src),
        .i_cmd_dst      (cmd_dst),
        .i_cmd_cnt      (cmd_cnt),
        .o_rf_raddr     (rf_raddr),
        .i_rf_rdata     (rf_rdata),
        .o_rf_we        (rf_we),
        .o_rf_waddr     (rf_waddr),
        .o_rf_wdata     (rf_wdata),
        .o_dp_oprd      (dp_oprd),
        .o_dp_clr       (dp_clr),
        .o_dp_swap_n_mov(dp_swap),
        .i_dp_tout      (dp_tout),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dp_tout = dp_clr  ? 8'h00 :
                     dp_swap ? {dp_oprd[3:0], dp_oprd[7:4]} : dp_oprd;

    // Register file: synchronous read, preloaded while the bench holds reset
    always @(posedge clk) begin
        if (rst && nvec == 0) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
            mem[0] <= 8'h12;
            mem[1] <= 8'h3C;
            mem[2] <= 8'hA5;
            mem[6] <= 8'h3C;
        end else if (rf_we) begin
            mem[rf_waddr] <= rf_wdata;
        end
        rf_rdata <= mem[rf_raddr];
    end

    always @(negedge clk) begin
        if (rf_we) wr_q.push_back({rf_waddr, rf_wdata});
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op,
                           input logic [2:0] src, input logic [2:0] dst,
                           input logic [3:0] cnt, input int exp_lat,
                           input logic exp_we, input logic [7:0] exp_wd,
                           input int exp_sw, input int exp_cl);
        int lat;
        int nsw;
        int ncl;
        lat = 0;
        nsw = 0;
        ncl = 0;
        chk({tag, ".ready"}, 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_cnt   = cnt;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (dp_swap) nsw++;
            if (dp_clr) ncl++;
            if (done) begin
                lat = k;
                break;
            end
            tick();
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".we"}, 32'(rf_we), 32'(exp_we));
        chk({tag, ".err"}, 32'(err), 32'(!exp_we));
        if (exp_we) begin
            chk({tag, ".waddr"}, 32'(rf_waddr), 32'(dst));
            chk({tag, ".wdata"}, 32'(rf_wdata), 32'(exp_wd));
        end
        chk({tag, ".nswap"}, 32'(nsw), 32'(exp_sw));
        chk({tag, ".nclr"}, 32'(ncl), 32'(exp_cl));
        tick();
        chk({tag, ".ready_back"}, 32'(cmd_ready), 1);
        chk({tag, ".done_off"}, 32'(done), 0);
    endtask

    task automatic send_held(input logic [1:0] op, input logic [2:0] src,
                             input logic [2:0] dst, output logic ok);
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_cnt   = 4'd0;
        for (int k = 0; k < 40; k++) begin
            if (cmd_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int   nwr;
        int   nd;
        logic ok;
        nvec      = 0;
        nerr      = 0;
        done_cnt  = 0;
        err_cnt   = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_src   = 3'd0;
        cmd_dst   = 3'd0;
        cmd_cnt   = 4'd0;
        tick();
        tick();
        chk("rst.ready", 32'(cmd_ready), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.raddr", 32'(rf_raddr), 0);
        chk("rst.outs", 32'({rf_we, done, err, dp_clr, dp_swap}), 0);
        chk("rst.oprd", 32'(dp_oprd), 0);
        rst = 1'b0;
        #1;
        chk("idle.ready", 32'(cmd_ready), 1);

        // MOV R2 -> R5, traced cycle by cycle
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_src   = 3'd2;
        cmd_dst   = 3'd5;
        cmd_cnt   = 4'd0;
        tick();
        cmd_valid = 1'b0;
        chk("mov.rd.busy", 32'(busy), 1);
        chk("mov.rd.ready", 32'(cmd_ready), 0);
        chk("mov.rd.raddr", 32'(rf_raddr), 2);
        chk("mov.rd.oprd", 32'(dp_oprd), 0);
        tick();
        chk("mov.ex.oprd", 32'(dp_oprd), 32'h0A5);
        chk("mov.ex.ctl", 32'({dp_clr, dp_swap}), 0);
        chk("mov.ex.we", 32'(rf_we), 0);
        tick();
        chk("mov.wb.we", 32'(rf_we), 1);
        chk("mov.wb.waddr", 32'(rf_waddr), 5);
        chk("mov.wb.wdata", 32'(rf_wdata), 32'h0A5);
        chk("mov.wb.done", 32'(done), 1);
        chk("mov.wb.ready", 32'(cmd_ready), 0);
        tick();
        chk("mov.idle.ready", 32'(cmd_ready), 1);
        chk("mov.idle.done", 32'(done), 0);
        chk("mov.mem5", 32'(mem[5]), 32'h0A5);

        run_cmd("swap11", 2'b01, 3'd1, 3'd1, 4'd0, 3, 1'b1, 8'hC3, 1, 0);
        run_cmd("swap66c1", 2'b01, 3'd6, 3'd6, 4'd1, 4, 1'b1, 8'h3C, 2, 0);
        run_cmd("clr7", 2'b10, 3'd4, 3'd7, 4'd0, 2, 1'b1, 8'h00, 0, 1);
        run_cmd("movmax", 2'b00, 3'd2, 3'd3, 4'd15, 18, 1'b1, 8'hA5, 0, 0);
        run_cmd("swapmax", 2'b01, 3'd6, 3'd4, 4'd15, 18, 1'b1, 8'h3C, 16, 0);

        nwr = wr_q.size();
        nd  = err_cnt;
        run_cmd("resv", 2'b11, 3'd0, 3'd0, 4'd0, 1, 1'b0, 8'h00, 0, 0);
        chk("resv.nowrite", 32'(wr_q.size()), 32'(nwr));
        chk("resv.errcnt", 32'(err_cnt), 32'(nd + 1));

        // Abort a long SWAP part way through EXEC
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_src   = 3'd1;
        cmd_dst   = 3'd6;
        cmd_cnt   = 4'd15;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("abort.inexec", 32'(dp_swap), 1);
        nwr = wr_q.size();
        nd  = done_cnt;
        rst = 1'b1;
        tick();
        chk("abort.busy", 32'(busy), 0);
        chk("abort.outs", 32'({rf_we, done, err, dp_clr, dp_swap}), 0);
        chk("abort.oprd", 32'(dp_oprd), 0);
        chk("abort.raddr", 32'(rf_raddr), 0);
        chk("abort.ready", 32'(cmd_ready), 0);
        rst = 1'b0;
        tick();
        tick();
        chk("abort.nowrite", 32'(wr_q.size()), 32'(nwr));
        chk("abort.nodone", 32'(done_cnt), 32'(nd));
        chk("abort.mem6", 32'(mem[6]), 32'h03C);
        run_cmd("postabort", 2'b00, 3'd2, 3'd3, 4'd0, 3, 1'b1, 8'hA5, 0, 0);

        // Three commands queued behind a continuously held valid
        wr_q.delete();
        nd = done_cnt;
        send_held(2'b00, 3'd0, 3'd1, ok);
        chk("q1.accept", 32'(ok), 1);
        send_held(2'b01, 3'd1, 3'd2, ok);
        chk("q2.accept", 32'(ok), 1);
        send_held(2'b10, 3'd5, 3'd0, ok);
        chk("q3.accept", 32'(ok), 1);
        cmd_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            tick();
        end
        tick();
        chk("q.busy", 32'(busy), 0);
        chk("q.nwr", 32'(wr_q.size()), 3);
        chk("q.ndone", 32'(done_cnt), 32'(nd + 3));
        if (wr_q.size() == 3) begin
            chk("q.wr0", 32'(wr_q[0]), 32'({3'd1, 8'h12}));
            chk("q.wr1", 32'(wr_q[1]), 32'({3'd2, 8'h21}));
            chk("q.wr2", 32'(wr_q[2]), 32'({3'd0, 8'h00}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
